// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch slice.
// IF/ID bundle layout, NOP encoding and default PC values.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  DEFAULT_END_PC   = 32'h0000_0060;

    typedef struct packed {
        logic               valid;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_plus4;
        logic [INSTR_W-1:0] instr;
    } if_id_t;

    typedef enum logic {
        S_FETCH,
        S_HALT
    } ifu_state_e;

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with hold (stall) and flush (redirect).
// Flush clears valid/instr only; pc fields keep their last value.
module if_id_pipe_reg
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic               flush,
    input  logic               d_valid,
    input  logic [ADDR_W-1:0]  d_pc,
    input  logic [ADDR_W-1:0]  d_pc_plus4,
    input  logic [INSTR_W-1:0] d_instr,
    output logic               q_valid,
    output logic [ADDR_W-1:0]  q_pc,
    output logic [ADDR_W-1:0]  q_pc_plus4,
    output logic [INSTR_W-1:0] q_instr
);

    if_id_t q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
        end else if (!hold) begin
            q.valid    <= d_valid;
            q.pc       <= d_pc;
            q.pc_plus4 <= d_pc_plus4;
            q.instr    <= d_instr;
        end
    end

    assign q_valid    = q.valid;
    assign q_pc       = q.pc;
    assign q_pc_plus4 = q.pc_plus4;
    assign q_instr    = q.instr;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, imem request tracking, IF/ID load.
// Define IFETCH_HALT_EN to stop fetching at END_PC (FETCH/HALT FSM).
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] END_PC   = DEFAULT_END_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr,
    output logic        halted
);

    logic [31:0] fetch_pc, fetch_pc_d;
    logic [31:0] req_pc, req_pc_d;
    logic        req_valid, req_valid_d;
    logic [31:0] tgt;
    logic        in_halt, redir_ok, issue_ok, go_halt;
    logic        do_redir, do_hold, do_run;

    assign tgt = {redirect_pc[31:2], 2'b00};

`ifdef IFETCH_HALT_EN
    ifu_state_e state, state_d;

    assign in_halt  = (state == S_HALT);
    assign redir_ok = redirect && (!in_halt || tgt < END_PC);
    assign issue_ok = !in_halt && (fetch_pc < END_PC);
    // Enter HALT only once nothing is in flight or in IF/ID.
    assign go_halt  = !in_halt && !issue_ok && !req_valid && !ifid_valid;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (1'b1)
            do_redir: state_d = S_FETCH;
            do_run && go_halt: state_d = S_HALT;
            default: state_d = state;
        endcase
    end

    assign halted = in_halt;
`else
    assign in_halt  = 1'b0;
    assign redir_ok = redirect;
    assign issue_ok = 1'b1;
    assign go_halt  = 1'b0;
    assign halted   = 1'b0;
`endif

    assign do_redir = redir_ok;
    assign do_hold  = !redirect && stall && !in_halt;
    assign do_run   = !do_redir && !do_hold;

    always_comb begin
        fetch_pc_d  = fetch_pc;
        req_pc_d    = req_pc;
        req_valid_d = req_valid;
        unique case (1'b1)
            do_redir: begin
                req_valid_d = 1'b1;
                req_pc_d    = tgt;
                fetch_pc_d  = tgt + 32'd4;
            end
            do_hold: begin
                req_valid_d = req_valid;
            end
            do_run: begin
                if (issue_ok) begin
                    req_valid_d = 1'b1;
                    req_pc_d    = fetch_pc;
                    fetch_pc_d  = fetch_pc + 32'd4;
                end else begin
                    req_valid_d = 1'b0;
                end
            end
            default: req_valid_d = req_valid;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            req_pc    <= '0;
            req_valid <= 1'b0;
        end else begin
            fetch_pc  <= fetch_pc_d;
            req_pc    <= req_pc_d;
            req_valid <= req_valid_d;
        end
    end

    // Stall re-presents req_pc so imem_instr keeps the in-flight word.
    always_comb begin
        imem_pc = fetch_pc;
        if (reset)         imem_pc = RESET_PC;
        else if (redirect) imem_pc = tgt;
        else if (stall)    imem_pc = req_pc;
    end

    if_id_pipe_reg u_ifid (
        .clk        (clk),
        .reset      (reset),
        .hold       (do_hold),
        .flush      (do_redir),
        .d_valid    (req_valid),
        .d_pc       (req_pc),
        .d_pc_plus4 (req_pc + 32'd4),
        .d_instr    (req_valid ? imem_instr : NOP_INSTR),
        .q_valid    (ifid_valid),
        .q_pc       (ifid_pc),
        .q_pc_plus4 (ifid_pc_plus4),
        .q_instr    (ifid_instr)
    );

endmodule
